// File: rtl/trace_column_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : trace_column_gen_if
// Description : Sample-stream and column-output bundle of trace_column_gen.
//               master = sample source / display side, slave = generator.
//               enable, sample_in, sample_valid : run control and sample stream
//               y_out, shift_enable             : row and shift pulse to bitmap
//               column_count, frame_done        : scrolled-column bookkeeping
// Revision    : 1.0 - initial release
// ============================================================================
interface trace_column_gen_if #(
    parameter int SAMPLE_W = 12
);
    logic                enable;
    logic [SAMPLE_W-1:0] sample_in;
    logic                sample_valid;
    logic [6:0]          y_out;
    logic                shift_enable;
    logic [6:0]          column_count;
    logic                frame_done;

    modport master (
        output enable, sample_in, sample_valid,
        input  y_out, shift_enable, column_count, frame_done
    );

    modport slave (
        input  enable, sample_in, sample_valid,
        output y_out, shift_enable, column_count, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/trace_column_gen.sv
`default_nettype none
// ============================================================================
// Module      : trace_column_gen
// Description : Averages blocks of 2^DECIM_LOG2 unsigned samples, scales the
//               average to a bitmap row (row 0 = top) and emits one
//               shift_enable pulse per block, counting columns modulo 128.
// Ports       : clk  - system clock (rising edge)
//               rst  - asynchronous active-high reset
//               bus  - trace_column_gen_if.slave (sample stream in,
//                      y_out/shift_enable/column_count/frame_done out)
// Revision    : 1.0 - initial release
// ============================================================================
module trace_column_gen #(
    parameter int SAMPLE_W   = 12,
    parameter int DECIM_LOG2 = 4,
    parameter int ROWS       = 120
) (
    input  wire logic            clk,
    input  wire logic            rst,
    trace_column_gen_if.slave    bus
);
    localparam int c_ACC_W  = SAMPLE_W + DECIM_LOG2;
    localparam int c_CNT_W  = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam int c_PROD_W = SAMPLE_W + 7;

    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'((1 << DECIM_LOG2) - 1);
    localparam logic [6:0]          c_ROW_MAX  = 7'(ROWS - 1);
    localparam logic [c_PROD_W-1:0] c_ROWS_W   = c_PROD_W'(ROWS);

    // Stage A: accumulator and sample counter
    logic [c_ACC_W-1:0]  acc_q, acc_d;
    logic [c_CNT_W-1:0]  cnt_q, cnt_d;
    // Stage A -> B: captured block sum
    logic [c_ACC_W-1:0]  sum_q, sum_d;
    logic                sum_vld_q, sum_vld_d;
    // Stage B -> C: block average
    logic [SAMPLE_W-1:0] avg_q, avg_d;
    logic                avg_vld_q, avg_vld_d;
    // Stage C: outputs
    logic [6:0]          y_out_q, y_out_d;
    logic                shift_q, shift_d;
    logic [6:0]          col_q, col_d;
    logic                frame_q, frame_d;

    logic                w_last;
    logic [c_ACC_W-1:0]  w_sum;
    logic [c_PROD_W-1:0] w_prod;
    logic [6:0]          w_scaled;

    assign w_last   = (cnt_q == c_CNT_LAST);
    assign w_sum    = acc_q + c_ACC_W'(bus.sample_in);
    // avg < 2^SAMPLE_W and ROWS <= 128, so the product fits SAMPLE_W+7 bits
    // and the top 7 bits are always <= ROWS-1.
    assign w_prod   = c_PROD_W'(avg_q) * c_ROWS_W;
    assign w_scaled = 7'(w_prod >> SAMPLE_W);

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        sum_vld_d = 1'b0;
        avg_d     = avg_q;
        avg_vld_d = 1'b0;
        y_out_d   = y_out_q;
        shift_d   = 1'b0;
        col_d     = col_q;
        frame_d   = 1'b0;

        if (!bus.enable) begin
            // Flush partial and in-flight blocks; y_out/column_count hold.
            acc_d = '0;
            cnt_d = '0;
        end else begin
            if (bus.sample_valid) begin
                if (w_last) begin
                    sum_d     = w_sum;
                    sum_vld_d = 1'b1;
                    acc_d     = '0;
                    cnt_d     = '0;
                end else begin
                    acc_d = w_sum;
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end

            if (sum_vld_q) begin
                avg_d     = SAMPLE_W'(sum_q >> DECIM_LOG2);
                avg_vld_d = 1'b1;
            end

            if (avg_vld_q) begin
                y_out_d = c_ROW_MAX - w_scaled;
                shift_d = 1'b1;
                col_d   = col_q + 7'd1;
                frame_d = (col_q == 7'd127);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            sum_q     <= '0;
            sum_vld_q <= 1'b0;
            avg_q     <= '0;
            avg_vld_q <= 1'b0;
            y_out_q   <= c_ROW_MAX;
            shift_q   <= 1'b0;
            col_q     <= 7'd0;
            frame_q   <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            sum_vld_q <= sum_vld_d;
            avg_q     <= avg_d;
            avg_vld_q <= avg_vld_d;
            y_out_q   <= y_out_d;
            shift_q   <= shift_d;
            col_q     <= col_d;
            frame_q   <= frame_d;
        end
    end

    assign bus.y_out        = y_out_q;
    assign bus.shift_enable = shift_q;
    assign bus.column_count = col_q;
    assign bus.frame_done   = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_trace_column_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_trace_column_gen
// Description : Self-checking bench for trace_column_gen (SAMPLE_W=12,
//               DECIM_LOG2=4, ROWS=120): table-driven single-block vectors
//               plus directed streaming, enable-low and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trace_column_gen;
    localparam int SW  = 12;
    localparam int DL  = 4;
    localparam int RW  = 120;
    localparam int BLK = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    trace_column_gen_if #(.SAMPLE_W(SW)) bus ();

    trace_column_gen #(
        .SAMPLE_W   (SW),
        .DECIM_LOG2 (DL),
        .ROWS       (RW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic [6:0] y;
        logic [6:0] cnt;
        logic       fd;
    } pulse_t;
    pulse_t pq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every cycle in which shift_enable is high.
    always @(posedge clk) begin
        #2;
        if (bus.shift_enable !== 1'b0)
            pq.push_back('{cyc, bus.y_out, bus.column_count, bus.frame_done});
    end

    typedef struct {
        string      name;
        logic [11:0] a;
        logic [11:0] b;
        bit          gaps;
        logic [6:0]  ey;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [11:0] s);
        bus.sample_valid = v;
        bus.sample_in    = s;
        tick();
    endtask

    // 16 valid samples: first 8 of a, last 8 of b; optional idle gaps.
    task automatic send_block(input logic [11:0] a, input logic [11:0] b,
                              input bit gaps, output int last);
        for (int i = 0; i < BLK; i++) begin
            if (gaps && (i % 3 == 1)) drive(1'b0, 12'hABC);
            drive(1'b1, (i < BLK/2) ? a : b);
            last = cyc;
        end
        bus.sample_valid = 1'b0;
    endtask

    task automatic expect_pulse(input string nm, input int last,
                                input logic [6:0] ey, input logic [6:0] ecnt);
        pulse_t p;
        bus.sample_valid = 1'b0;
        tick(); tick(); tick();
        chk({nm, "_npulse"}, pq.size(), 1);
        if (pq.size() > 0) begin
            p = pq.pop_front();
            chk({nm, "_lat"},   p.cyc, last + 2);
            chk({nm, "_y"},     p.y,   ey);
            chk({nm, "_cnt"},   p.cnt, ecnt);
            chk({nm, "_fd"},    p.fd,  1'b0);
        end
        chk({nm, "_yhold"}, bus.y_out, ey);
        chk({nm, "_se_lo"}, bus.shift_enable, 1'b0);
        pq.delete();
    endtask

    initial begin
        int last;
        int first;
        int v;
        pulse_t p;

        vecs[0] = '{"zero",    12'd0,    12'd0,    1'b0, 7'd119};
        vecs[1] = '{"full",    12'd4095, 12'd4095, 1'b0, 7'd0};
        vecs[2] = '{"half",    12'd2048, 12'd2048, 1'b0, 7'd59};
        vecs[3] = '{"gapmix",  12'd0,    12'd4095, 1'b1, 7'd60};
        vecs[4] = '{"k1000",   12'd1000, 12'd1000, 1'b0, 7'd90};
        vecs[5] = '{"mix200",  12'd100,  12'd300,  1'b0, 7'd114};
        vecs[6] = '{"trunc34", 12'd34,   12'd35,   1'b0, 7'd119};
        vecs[7] = '{"gapfull", 12'd4095, 12'd4095, 1'b1, 7'd0};

        bus.enable       = 1'b1;
        bus.sample_valid = 1'b0;
        bus.sample_in    = '0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();

        chk("rst_y",   bus.y_out, 7'd119);
        chk("rst_cnt", bus.column_count, 7'd0);
        chk("rst_se",  bus.shift_enable, 1'b0);
        chk("rst_fd",  bus.frame_done, 1'b0);

        // Table-driven single blocks
        for (int k = 0; k < 8; k++) begin
            pq.delete();
            send_block(vecs[k].a, vecs[k].b, vecs[k].gaps, last);
            expect_pulse(vecs[k].name, last, vecs[k].ey, 7'(k + 1));
        end

        // 128 back-to-back blocks from a fresh reset
        rst = 1'b1; tick(); rst = 1'b0; tick();
        pq.delete();
        first = 0;
        for (int b = 0; b < 128; b++) begin
            v = (b * 33) % 4096;
            for (int i = 0; i < BLK; i++) drive(1'b1, 12'(v));
            if (b == 0) first = cyc + 2;
        end
        bus.sample_valid = 1'b0;
        tick(); tick(); tick();
        chk("stream_npulse", pq.size(), 128);
        for (int i = 0; i < 128 && pq.size() > 0; i++) begin
            p = pq.pop_front();
            v = (i * 33) % 4096;
            chk($sformatf("stream_lat%0d", i), p.cyc, first + BLK * i);
            chk($sformatf("stream_y%0d", i),   p.y,   RW - 1 - ((v * RW) >> SW));
            chk($sformatf("stream_cnt%0d", i), p.cnt, (i + 1) % 128);
            chk($sformatf("stream_fd%0d", i),  p.fd,  (i == 127) ? 1 : 0);
        end
        chk("stream_cnt_end", bus.column_count, 7'd0);
        pq.delete();

        // Known state, then partial block aborted by enable low
        send_block(12'd2048, 12'd2048, 1'b0, last);
        expect_pulse("pre_en", last, 7'd59, 7'd1);
        for (int i = 0; i < 10; i++) drive(1'b1, 12'd4095);
        bus.enable = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b1, 12'd4095);
        bus.enable = 1'b1;
        bus.sample_valid = 1'b0;
        chk("enlo_y",      bus.y_out, 7'd59);
        chk("enlo_cnt",    bus.column_count, 7'd1);
        chk("enlo_npulse", pq.size(), 0);
        send_block(12'd4095, 12'd4095, 1'b0, last);
        expect_pulse("post_en", last, 7'd0, 7'd2);

        // Completed block dropped while in flight
        send_block(12'd2048, 12'd2048, 1'b0, last);
        bus.enable = 1'b0;
        tick(); tick(); tick(); tick();
        bus.enable = 1'b1;
        chk("inflight_npulse", pq.size(), 0);
        chk("inflight_y",      bus.y_out, 7'd0);
        chk("inflight_cnt",    bus.column_count, 7'd2);

        // Final sample lands in the cycle enable falls
        for (int i = 0; i < BLK - 1; i++) drive(1'b1, 12'd0);
        bus.enable = 1'b0;
        drive(1'b1, 12'd0);
        bus.enable = 1'b1;
        bus.sample_valid = 1'b0;
        tick(); tick(); tick();
        chk("fall_npulse", pq.size(), 0);
        send_block(12'd2048, 12'd2048, 1'b0, last);
        expect_pulse("post_fall", last, 7'd59, 7'd3);

        // Reset mid-block
        for (int i = 0; i < 10; i++) drive(1'b1, 12'd0);
        rst = 1'b1;
        drive(1'b0, 12'd0);
        rst = 1'b0;
        chk("midrst_y",      bus.y_out, 7'd119);
        chk("midrst_cnt",    bus.column_count, 7'd0);
        chk("midrst_se",     bus.shift_enable, 1'b0);
        chk("midrst_npulse", pq.size(), 0);
        send_block(12'd4095, 12'd4095, 1'b0, last);
        expect_pulse("post_rst", last, 7'd0, 7'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/trace_column_gen.md
# trace_column_gen

Upstream stage of the scrolling trace bitmap. It takes a stream of unsigned ADC samples, averages each block of 2^DECIM_LOG2 valid samples, and scales the average to a row index in 0..ROWS-1 with row 0 at the top. It then issues the one-cycle `shift_enable` pulse and the `y_out` row that the 128x120 bitmap shifter consumes as its `shift_enable`/`y_in`. It also counts emitted columns so the display side knows when a full screen width has scrolled.

## Interface
- SAMPLE_W, 12, sample width in bits (unsigned).
- DECIM_LOG2, 4, log2 of samples averaged per column (0..8; 0 = one sample per column).
- ROWS, 120, bitmap height (1..128).

- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run control; low flushes the block.
- sample_in  in  SAMPLE_W  unsigned sample.
- sample_valid  in  1  sample_in valid this cycle.
- y_out  out  7  row index for the bitmap, held between pulses.
- shift_enable  out  1  one-cycle pulse: bitmap shifts and inserts at y_out.
- column_count  out  7  columns emitted modulo 128.
- frame_done  out  1  one-cycle pulse coincident with the shift_enable that wraps column_count 127->0.

## Operation
- Reset values: y_out = ROWS-1 (bottom row), shift_enable = 0, column_count = 0, frame_done = 0. Accumulator, sample counter and pipeline valids are 0.
- Stage A, accumulate:
  - acc is SAMPLE_W+DECIM_LOG2 bits and cannot overflow.
  - On each sample_valid with enable high: acc += sample_in and sample counter increments.
  - On the 2^DECIM_LOG2-th sample: acc+sample_in is captured, acc and the counter clear, and the stage B valid is set.
  - sample_valid may be high every cycle, so block N+1 accumulates while block N is in flight.
- Stage B, average: avg = captured_sum >> DECIM_LOG2, truncating. avg is registered.
- Stage C, scale:
  - scaled = (avg * ROWS) >> SAMPLE_W. The product is SAMPLE_W+7 bits, and scaled is always <= ROWS-1.
  - y_out <= ROWS-1 - scaled, so high amplitude maps to the top.
  - shift_enable pulses for exactly one cycle.
  - column_count increments, wrapping 127->0. frame_done pulses on the wrap.
- enable low, level-sensitive:
  - sample_valid is ignored.
  - acc, the sample counter and all in-flight pipeline valids clear. No pulse is emitted for a partial or in-flight block.
  - y_out and column_count hold.
- enable rising: accumulation starts fresh. A full 2^DECIM_LOG2 samples are required before the next pulse.
- Reset mid-operation discards any partial block and any in-flight block, and all outputs return to their reset values.

## Timing
- Latency: the final sample of a block is accepted at edge T. The average registers at T+1. y_out and shift_enable update at T+2. shift_enable is high for the cycle following T+2.
- y_out changes only on the same edge that raises shift_enable, so it is stable when the bitmap samples it.
- Minimum pulse spacing is 2^DECIM_LOG2 cycles, i.e. every cycle when DECIM_LOG2 = 0 with continuous valid. The pipeline never stalls and never drops a completed block while enable is high.
- If the final sample of a block arrives in the cycle enable falls, the block is dropped.
- No backpressure: the downstream bitmap accepts a shift every cycle.

## Test plan
- Reset, then 16 consecutive valid samples of 0 (DECIM_LOG2 = 4). Required: one shift_enable pulse 2 cycles after the 16th sample, y_out = 119, column_count = 1.
- 16 samples of 4095. Required: scaled = 119, y_out = 0.
- 16 samples of 2048. Required: y_out = 59.
- 8 samples of 0 then 8 of 4095, with gaps in sample_valid. Required: sum 32760, avg 2047, scaled 59, y_out = 60. No pulse occurs before the 16th valid.
- Stream 128 full blocks back to back with valid high every cycle. Required:
  - pulses are exactly 16 cycles apart;
  - frame_done is high only with the 128th pulse;
  - column_count reads 0 after that pulse.
- Give 10 samples, then rst high for 1 cycle (or enable low for 3 cycles), then 16 samples of 4095. Required:
  - no pulse from the partial block;
  - after rst, y_out reads 119 and column_count reads 0;
  - after enable low, y_out and column_count hold their prior values;
  - the next pulse arrives 2 cycles after the 16th new sample, with y_out = 0.
